msk_frame_sync: RTL

MSK_FRAME_SYNC -- requirements
Module: msk_frame_sync

---
 rtl/msk_fsync_pkg.sv | 24 ++
 rtl/msk_sync_corr.sv | 27 ++
 rtl/msk_frame_sync.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/msk_fsync_pkg.sv
// Shared types and helpers for the MSK frame synchroniser: state enum,
// default sync word and a width-generic popcount.
package msk_fsync_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    localparam logic [31:0] DEFAULT_SYNC_WORD = 32'h1ACF_FC1D;

    // Widest sync word the popcount helper supports; narrower words are zero-extended.
    localparam int MAX_SYNC_W = 64;

    function automatic logic [6:0] popcount(input logic [MAX_SYNC_W-1:0] v);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_SYNC_W; i++) begin
            cnt = cnt + 7'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/msk_sync_corr.sv
// Hamming-distance correlator: flags a true or bit-inverted sync word match
// within MAX_ERR mismatches.
module msk_sync_corr
    import msk_fsync_pkg::*;
#(
    parameter int SYNC_W  = 32,
    parameter int MAX_ERR = 2,
    parameter bit INV_EN  = 1'b0
) (
    input  logic [SYNC_W-1:0] sr_next,
    input  logic [SYNC_W-1:0] pattern,
    output logic              true_match,
    output logic              inv_match
);

    logic [6:0] dist_true;
    logic [6:0] dist_inv;

    always_comb begin
        dist_true = popcount(MAX_SYNC_W'(sr_next ^ pattern));
        dist_inv  = popcount(MAX_SYNC_W'(sr_next ^ ~pattern));
    end

    assign true_match = (dist_true <= 7'(MAX_ERR));
    assign inv_match  = INV_EN && (dist_inv <= 7'(MAX_ERR));

endmodule

// File: rtl/msk_frame_sync.sv
// MSK frame synchroniser: hunts for the sync word, then assembles LEN_BYTES
// payload bytes MSB-first. Define MSK_FSYNC_INV_DET_EN to also lock on inverted sync.
module msk_frame_sync
    import msk_fsync_pkg::*;
#(
    parameter int                SYNC_W    = 32,
    parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(DEFAULT_SYNC_WORD),
    parameter int                MAX_ERR   = 2,
    parameter int                LEN_BYTES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_i,
    input  logic        data_val_i,
    output logic [7:0]  byte_o,
    output logic        byte_val_o,
    output logic        sof_o,
    output logic        eof_o,
    output logic        sync_det_o,
    output logic        locked_o,
    output logic        inv_o,
    output logic [15:0] frame_cnt_o
);

`ifdef MSK_FSYNC_INV_DET_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    localparam logic [7:0] LAST_BYTE = 8'(LEN_BYTES - 1);

    state_t            state, state_next;
    logic [SYNC_W-1:0] sr;
    logic [SYNC_W-1:0] sr_next;
    logic [2:0]        bit_cnt;
    logic [7:0]        byte_cnt;
    logic [7:0]        byte_sr;
    logic              inv_q;
    logic              match_true, match_inv;
    logic              sync_hit, sync_inv, last_bit, frame_done;
    logic              pay_bit;

    assign sr_next = {sr[SYNC_W-2:0], data_i};
    assign pay_bit = data_i ^ inv_q;

    msk_sync_corr #(
        .SYNC_W  (SYNC_W),
        .MAX_ERR (MAX_ERR),
        .INV_EN  (INV_EN)
    ) u_corr (
        .sr_next    (sr_next),
        .pattern    (SYNC_WORD),
        .true_match (match_true),
        .inv_match  (match_inv)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= HUNT;
        else     state <= state_next;
    end

    // A true match is checked first so it wins over a simultaneous inverted match.
    always_comb begin
        state_next = state;
        sync_hit   = 1'b0;
        sync_inv   = 1'b0;
        last_bit   = 1'b0;
        frame_done = 1'b0;
        if (data_val_i) begin
            case (state)
                HUNT: begin
                    if (match_true) begin
                        sync_hit   = 1'b1;
                        state_next = PAYLOAD;
                    end else if (match_inv) begin
                        sync_hit   = 1'b1;
                        sync_inv   = 1'b1;
                        state_next = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (bit_cnt == 3'd7) begin
                        last_bit = 1'b1;
                        if (byte_cnt == LAST_BYTE) begin
                            frame_done = 1'b1;
                            state_next = HUNT;
                        end
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr          <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            byte_sr     <= '0;
            byte_o      <= '0;
            byte_val_o  <= 1'b0;
            sof_o       <= 1'b0;
            eof_o       <= 1'b0;
            sync_det_o  <= 1'b0;
            inv_q       <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            byte_val_o <= 1'b0;
            sof_o      <= 1'b0;
            eof_o      <= 1'b0;
            sync_det_o <= 1'b0;
            if (data_val_i) begin
                sr <= frame_done ? '0 : sr_next;
                if (sync_hit) begin
                    sync_det_o <= 1'b1;
                    inv_q      <= sync_inv;
                    bit_cnt    <= '0;
                    byte_cnt   <= '0;
                end
                if (state == PAYLOAD) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    byte_sr <= {byte_sr[6:0], pay_bit};
                    if (last_bit) begin
                        byte_o     <= {byte_sr[6:0], pay_bit};
                        byte_val_o <= 1'b1;
                        sof_o      <= (byte_cnt == 8'd0);
                        eof_o      <= frame_done;
                        byte_cnt   <= byte_cnt + 8'd1;
                    end
                    if (frame_done) begin
                        inv_q       <= 1'b0;
                        byte_cnt    <= '0;
                        frame_cnt_o <= frame_cnt_o + 16'd1;
                    end
                end
            end
        end
    end

    assign locked_o = (state == PAYLOAD);
    assign inv_o    = inv_q;

endmodule
